// File: rtl/mini_i_cache_pkg.sv
// mini_i_cache_pkg
// Shared definitions for the direct-mapped, multi-word-line instruction cache:
//   - state_e   : controller states
//   - off_bits / idx_bits / tag_bits : address-split widths
//   - vec_bits  : width of a vector that must exist even when its field is empty
//   - sat_inc   : saturating increment for counters up to 64 bits wide
package mini_i_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_ADDR,
    REFILL_DATA,
    RESPOND
  } state_e;

  function automatic int off_bits(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int idx_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int addr_width, input int lines, input int words_per_line);
    return addr_width - $clog2(lines) - $clog2(words_per_line);
  endfunction

  // A one-word line has no offset field, but the word counter still needs a bit.
  function automatic int vec_bits(input int width);
    return (width < 1) ? 1 : width;
  endfunction

  // Counters are passed zero-extended to 64 bits; 'width' says where all-ones sits.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
    logic [63:0] all_ones;
    all_ones = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    return (value == all_ones) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/mini_i_cache_line_store.sv
// mini_i_cache_line_store
// Valid/tag/data storage for the direct-mapped cache. Only the valid bits are
// reset; tag and data contents are meaningless until their valid bit is set.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   line_idx                : line selected for lookup, write, tag set, invalidate
//   rd_off, rd_tag          : word offset and tag for the combinational lookup
//   hit, rd_data            : lookup result and the addressed word
//   wr_en, wr_off, wr_data  : refill word write into line_idx
//   tag_set, tag_valid, tag_value : write the tag and set the valid bit value
//   inval_en                : clear the valid bit of line_idx
//   clear_all               : clear every valid bit (wins over tag_set/inval_en)
module mini_i_cache_line_store
  import mini_i_cache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int IDX_W          = 4,
  parameter int OFF_VW         = 2,
  parameter int TAG_W          = 26
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [IDX_W-1:0]      line_idx,
  input  logic [OFF_VW-1:0]     rd_off,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [OFF_VW-1:0]     wr_off,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  tag_set,
  input  logic                  tag_valid,
  input  logic [TAG_W-1:0]      tag_value,
  input  logic                  inval_en,
  input  logic                  clear_all
);

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_mem  [LINES];
  logic [DATA_WIDTH-1:0] data_mem [LINES][WORDS_PER_LINE];

  // Flush has priority so a line finishing its refill under a flush ends invalid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (clear_all) begin
      valid_q <= '0;
    end else if (tag_set) begin
      valid_q[line_idx] <= tag_valid;
    end else if (inval_en) begin
      valid_q[line_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      data_mem[line_idx][wr_off] <= wr_data;
    end
    if (tag_set) begin
      tag_mem[line_idx] <= tag_value;
    end
  end

  assign hit     = valid_q[line_idx] && (tag_mem[line_idx] == rd_tag);
  assign rd_data = data_mem[line_idx][rd_off];

endmodule

// File: rtl/mini_i_cache_lines.sv
// mini_i_cache_lines
// Direct-mapped, word-addressed instruction cache with multi-word lines.
// A miss refills the whole line one word at a time (offset 0 upward) with at
// most one bus request outstanding; the requested word is captured on the fly.
// Ports:
//   clock, reset_n                         : clock, asynchronous active-low reset
//   ir_addr_valid/ready, ir_addr           : fetch request from the CPU
//   ir_data_valid/ready, ir_data           : fetch reply to the CPU
//   bus_ir_addr_valid/ready, bus_ir_addr   : word-read request to memory
//   bus_ir_data_valid/ready, bus_ir_data   : word-read reply from memory
//   flush                                  : one-cycle pulse, invalidate all lines
//   hit_count, miss_count                  : saturating performance counters
module mini_i_cache_lines
  import mini_i_cache_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  ir_addr_valid,
  output logic                  ir_addr_ready,
  input  logic [ADDR_WIDTH-1:0] ir_addr,
  output logic                  ir_data_valid,
  input  logic                  ir_data_ready,
  output logic [DATA_WIDTH-1:0] ir_data,
  output logic                  bus_ir_addr_valid,
  input  logic                  bus_ir_addr_ready,
  output logic [ADDR_WIDTH-1:0] bus_ir_addr,
  input  logic                  bus_ir_data_valid,
  output logic                  bus_ir_data_ready,
  input  logic [DATA_WIDTH-1:0] bus_ir_data,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int OFF_W  = off_bits(WORDS_PER_LINE);
  localparam int IDX_W  = idx_bits(LINES);
  localparam int TAG_W  = tag_bits(ADDR_WIDTH, LINES, WORDS_PER_LINE);
  localparam int OFF_VW = vec_bits(OFF_W);

  state_e state, next_state;

  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [IDX_W-1:0]      req_idx;
  logic [OFF_VW-1:0]     req_off;
  logic [TAG_W-1:0]      req_tag;
  logic [OFF_VW-1:0]     word_cnt;
  logic                  last_word;
  logic                  flush_pending;

  logic                  store_hit;
  logic [DATA_WIDTH-1:0] store_rd_data;

  logic                  lookup_hit;
  logic                  refill_done;
  logic                  wr_en;
  logic                  tag_set;
  logic                  tag_valid;
  logic                  inval_en;
  logic                  clear_all;

  logic [63:0]           hit_ext;
  logic [63:0]           miss_ext;

  // Address split done arithmetically so a one-word line (empty offset) needs no special case.
  assign req_idx   = IDX_W'(req_addr >> OFF_W);
  assign req_off   = OFF_VW'(req_addr & ADDR_WIDTH'(WORDS_PER_LINE - 1));
  assign req_tag   = TAG_W'(req_addr >> (OFF_W + IDX_W));
  assign line_base = req_addr & ~ADDR_WIDTH'(WORDS_PER_LINE - 1);
  assign last_word = (word_cnt == OFF_VW'(WORDS_PER_LINE - 1));

  assign ir_addr_ready     = (state == IDLE) && reset_n;
  assign ir_data_valid     = (state == RESPOND);
  assign bus_ir_addr_valid = (state == REFILL_ADDR);
  assign bus_ir_data_ready = (state == REFILL_DATA);

  mini_i_cache_line_store #(
    .DATA_WIDTH     (DATA_WIDTH),
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .IDX_W          (IDX_W),
    .OFF_VW         (OFF_VW),
    .TAG_W          (TAG_W)
  ) u_line_store (
    .clock     (clock),
    .reset_n   (reset_n),
    .line_idx  (req_idx),
    .rd_off    (req_off),
    .rd_tag    (req_tag),
    .hit       (store_hit),
    .rd_data   (store_rd_data),
    .wr_en     (wr_en),
    .wr_off    (word_cnt),
    .wr_data   (bus_ir_data),
    .tag_set   (tag_set),
    .tag_valid (tag_valid),
    .tag_value (req_tag),
    .inval_en  (inval_en),
    .clear_all (clear_all)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    lookup_hit  = 1'b0;
    refill_done = 1'b0;
    wr_en       = 1'b0;
    tag_set     = 1'b0;
    tag_valid   = 1'b0;
    inval_en    = 1'b0;
    clear_all   = 1'b0;
    case (state)
      IDLE: begin
        clear_all = flush;
        if (ir_addr_valid) begin
          next_state = LOOKUP;
        end
      end
      LOOKUP: begin
        // A flush arriving with the lookup must not let stale contents hit.
        clear_all  = flush;
        lookup_hit = store_hit && !flush;
        if (lookup_hit) begin
          next_state = RESPOND;
        end else begin
          inval_en   = 1'b1;
          next_state = REFILL_ADDR;
        end
      end
      REFILL_ADDR: begin
        if (bus_ir_addr_ready) begin
          next_state = REFILL_DATA;
        end
      end
      REFILL_DATA: begin
        if (bus_ir_data_valid) begin
          wr_en = 1'b1;
          if (last_word) begin
            // A flush seen at any point of the refill leaves every line, including this one, invalid.
            refill_done = 1'b1;
            tag_set     = 1'b1;
            tag_valid   = !(flush_pending || flush);
            clear_all   = flush_pending || flush;
            next_state  = RESPOND;
          end else begin
            next_state = REFILL_ADDR;
          end
        end
      end
      RESPOND: begin
        clear_all = flush;
        if (ir_data_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    hit_ext                  = '0;
    hit_ext[CNT_WIDTH-1:0]   = hit_count;
    miss_ext                 = '0;
    miss_ext[CNT_WIDTH-1:0]  = miss_count;
  end

  // Request address, refill progress, reply word, bus address and counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_addr      <= '0;
      word_cnt      <= '0;
      ir_data       <= '0;
      bus_ir_addr   <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      flush_pending <= 1'b0;
    end else begin
      if ((state == IDLE) && ir_addr_valid) begin
        req_addr <= ir_addr;
      end

      if (refill_done) begin
        flush_pending <= 1'b0;
      end else if (((state == REFILL_ADDR) || (state == REFILL_DATA)) && flush) begin
        flush_pending <= 1'b1;
      end

      if (state == LOOKUP) begin
        if (lookup_hit) begin
          ir_data   <= store_rd_data;
          hit_count <= CNT_WIDTH'(sat_inc(hit_ext, CNT_WIDTH));
        end else begin
          miss_count  <= CNT_WIDTH'(sat_inc(miss_ext, CNT_WIDTH));
          word_cnt    <= '0;
          bus_ir_addr <= line_base;
        end
      end

      if ((state == REFILL_DATA) && bus_ir_data_valid) begin
        if (word_cnt == req_off) begin
          ir_data <= bus_ir_data;
        end
        if (!last_word) begin
          word_cnt    <= word_cnt + 1'b1;
          bus_ir_addr <= line_base | ADDR_WIDTH'(word_cnt + 1'b1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mini_i_cache_lines.sv
// tb_mini_i_cache_lines
// Directed bench for mini_i_cache_lines with default parameters. The memory
// model answers word address A with A + 0x28, so line 0x78..0x7B returns
// 0xA0..0xA3. Inputs are driven and outputs sampled 1 ns after the falling edge.
module tb_mini_i_cache_lines;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        ir_addr_valid = 1'b0;
  logic        ir_addr_ready;
  logic [31:0] ir_addr = '0;
  logic        ir_data_valid;
  logic        ir_data_ready = 1'b0;
  logic [31:0] ir_data;
  logic        bus_ir_addr_valid;
  logic        bus_ir_addr_ready = 1'b0;
  logic [31:0] bus_ir_addr;
  logic        bus_ir_data_valid = 1'b0;
  logic        bus_ir_data_ready;
  logic [31:0] bus_ir_data = '0;
  logic        flush = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int          checks = 0;
  int          failures = 0;
  int          pos_count = 0;
  int          accept_pos = 0;
  int          addr_stall = 0;
  int          stall_left = 0;
  int          data_done = 0;
  logic        have_pending = 1'b0;
  logic [31:0] pend_addr = '0;
  logic [31:0] bus_log [$];

  mini_i_cache_lines dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .ir_addr_valid     (ir_addr_valid),
    .ir_addr_ready     (ir_addr_ready),
    .ir_addr           (ir_addr),
    .ir_data_valid     (ir_data_valid),
    .ir_data_ready     (ir_data_ready),
    .ir_data           (ir_data),
    .bus_ir_addr_valid (bus_ir_addr_valid),
    .bus_ir_addr_ready (bus_ir_addr_ready),
    .bus_ir_addr       (bus_ir_addr),
    .bus_ir_data_valid (bus_ir_data_valid),
    .bus_ir_data_ready (bus_ir_data_ready),
    .bus_ir_data       (bus_ir_data),
    .flush             (flush),
    .hit_count         (hit_count),
    .miss_count        (miss_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) pos_count <= pos_count + 1;

  // Memory model: each request is held off for addr_stall cycles, then accepted
  // and logged; the reply follows on the next cycle the cache is ready for it.
  always @(negedge clock) begin
    if (!reset_n) begin
      bus_ir_addr_ready = 1'b0;
      bus_ir_data_valid = 1'b0;
      bus_ir_data       = '0;
      have_pending      = 1'b0;
      stall_left        = addr_stall;
    end else begin
      if (bus_ir_addr_valid) begin
        if (stall_left > 0) begin
          bus_ir_addr_ready = 1'b0;
          stall_left        = stall_left - 1;
        end else begin
          bus_ir_addr_ready = 1'b1;
          bus_log.push_back(bus_ir_addr);
          pend_addr         = bus_ir_addr;
          have_pending      = 1'b1;
        end
      end else begin
        bus_ir_addr_ready = 1'b0;
        stall_left        = addr_stall;
      end
      if (bus_ir_data_ready && have_pending) begin
        bus_ir_data_valid = 1'b1;
        bus_ir_data       = pend_addr + 32'h28;
        have_pending      = 1'b0;
        data_done         = data_done + 1;
      end else begin
        bus_ir_data_valid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic pulseFlush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic issueFetch(input logic [31:0] addr, input logic with_flush);
    for (int i = 0; i < 50 && !ir_addr_ready; i++) tick();
    checkOutput("ir_addr_ready", {31'd0, ir_addr_ready}, 32'd1);
    ir_addr       = addr;
    ir_addr_valid = 1'b1;
    flush         = with_flush;
    tick();
    ir_addr_valid = 1'b0;
    flush         = 1'b0;
    accept_pos    = pos_count;
  endtask

  // Waits for the reply, checking the bus address never moves while stalled,
  // then holds ir_data_ready low for dready_stall cycles before consuming it.
  task automatic awaitData(input int dready_stall, output logic [31:0] data, output int latency);
    logic        prev_stalled;
    logic [31:0] prev_addr;
    int          guard;
    prev_stalled = 1'b0;
    prev_addr    = '0;
    guard        = 0;
    while (!ir_data_valid && guard < 400) begin
      if (prev_stalled && bus_ir_addr_valid) checkOutput("bus_addr_stable", bus_ir_addr, prev_addr);
      prev_stalled = bus_ir_addr_valid && !bus_ir_addr_ready;
      prev_addr    = bus_ir_addr;
      tick();
      guard = guard + 1;
    end
    checkOutput("ir_data_valid_seen", {31'd0, ir_data_valid}, 32'd1);
    latency = pos_count - accept_pos + 1;
    data    = ir_data;
    for (int i = 0; i < dready_stall; i++) begin
      tick();
      checkOutput("ir_data_hold", ir_data, data);
      checkOutput("ir_data_valid_hold", {31'd0, ir_data_valid}, 32'd1);
    end
    ir_data_ready = 1'b1;
    tick();
    ir_data_ready = 1'b0;
    checkOutput("ir_data_valid_drop", {31'd0, ir_data_valid}, 32'd0);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input int dready_stall,
                               output logic [31:0] data, output int latency);
    issueFetch(addr, 1'b0);
    awaitData(dready_stall, data, latency);
  endtask

  task automatic checkBusLine(input int start, input logic [31:0] base);
    checkOutput("bus_req_count", bus_log.size() - start, 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (start + i < bus_log.size()) checkOutput("bus_req_addr", bus_log[start + i], base + i);
    end
  endtask

  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, "_ir_addr_ready"},     {31'd0, ir_addr_ready},     32'd0);
    checkOutput({phase, "_ir_data_valid"},     {31'd0, ir_data_valid},     32'd0);
    checkOutput({phase, "_bus_ir_addr_valid"}, {31'd0, bus_ir_addr_valid}, 32'd0);
    checkOutput({phase, "_bus_ir_data_ready"}, {31'd0, bus_ir_data_ready}, 32'd0);
    checkOutput({phase, "_ir_data"},           ir_data,                    32'd0);
    checkOutput({phase, "_bus_ir_addr"},       bus_ir_addr,                32'd0);
    checkOutput({phase, "_hit_count"},         hit_count,                  32'd0);
    checkOutput({phase, "_miss_count"},        miss_count,                 32'd0);
  endtask

  initial begin
    logic [31:0] data;
    int          lat;
    int          start;
    int          base_done;

    #1 reset_n = 1'b0;
    #1 checkResetOutputs("reset");
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    checkOutput("ready_after_reset", {31'd0, ir_addr_ready}, 32'd1);

    $display("[TB] cold miss on 0x7B");
    start = bus_log.size();
    applyStimulus(32'h7B, 0, data, lat);
    checkOutput("cold_data", data, 32'hA3);
    checkOutput("cold_latency", lat, 32'd10);
    checkBusLine(start, 32'h78);
    checkOutput("cold_miss_count", miss_count, 32'd1);
    checkOutput("cold_hit_count", hit_count, 32'd0);

    $display("[TB] hit on 0x79");
    start = bus_log.size();
    applyStimulus(32'h79, 0, data, lat);
    checkOutput("hit_data", data, 32'hA1);
    checkOutput("hit_latency", lat, 32'd2);
    checkOutput("hit_no_bus", bus_log.size() - start, 32'd0);
    checkOutput("hit_hit_count", hit_count, 32'd1);
    checkOutput("hit_miss_count", miss_count, 32'd1);

    $display("[TB] conflict 0xBB evicts 0x7B");
    start = bus_log.size();
    applyStimulus(32'hBB, 0, data, lat);
    checkOutput("conflict_data", data, 32'hE3);
    checkBusLine(start, 32'hB8);
    checkOutput("conflict_miss_count", miss_count, 32'd2);
    start = bus_log.size();
    applyStimulus(32'h7B, 0, data, lat);
    checkOutput("evicted_data", data, 32'hA3);
    checkBusLine(start, 32'h78);
    checkOutput("evicted_miss_count", miss_count, 32'd3);

    $display("[TB] flush in IDLE");
    applyStimulus(32'h00, 0, data, lat);
    checkOutput("fill0_data", data, 32'h28);
    checkOutput("fill0_miss_count", miss_count, 32'd4);
    pulseFlush();
    start = bus_log.size();
    applyStimulus(32'h00, 0, data, lat);
    checkOutput("flushed_data", data, 32'h28);
    checkBusLine(start, 32'h00);
    checkOutput("flushed_miss_count", miss_count, 32'd5);

    $display("[TB] flush coincident with acceptance");
    start = bus_log.size();
    issueFetch(32'h01, 1'b1);
    awaitData(0, data, lat);
    checkOutput("coincident_data", data, 32'h29);
    checkBusLine(start, 32'h00);
    checkOutput("coincident_miss_count", miss_count, 32'd6);

    $display("[TB] flush during refill of 0x10");
    start = bus_log.size();
    issueFetch(32'h10, 1'b0);
    for (int i = 0; i < 50 && !bus_ir_data_ready; i++) tick();
    checkOutput("flush_window", {31'd0, bus_ir_data_ready}, 32'd1);
    pulseFlush();
    awaitData(0, data, lat);
    checkOutput("refill_flush_data", data, 32'h38);
    checkBusLine(start, 32'h10);
    checkOutput("refill_flush_miss_count", miss_count, 32'd7);
    start = bus_log.size();
    applyStimulus(32'h10, 0, data, lat);
    checkOutput("reread_data", data, 32'h38);
    checkBusLine(start, 32'h10);
    checkOutput("reread_miss_count", miss_count, 32'd8);
    start = bus_log.size();
    applyStimulus(32'h01, 0, data, lat);
    checkOutput("other_line_flushed_data", data, 32'h29);
    checkBusLine(start, 32'h00);
    checkOutput("other_line_miss_count", miss_count, 32'd9);
    start = bus_log.size();
    applyStimulus(32'h11, 0, data, lat);
    checkOutput("refilled_hit_data", data, 32'h39);
    checkOutput("refilled_hit_no_bus", bus_log.size() - start, 32'd0);
    checkOutput("refilled_hit_count", hit_count, 32'd2);

    $display("[TB] backpressure on both sides");
    addr_stall = 5;
    start = bus_log.size();
    applyStimulus(32'h25, 3, data, lat);
    checkOutput("bp_data", data, 32'h4D);
    checkOutput("bp_latency", lat, 32'd30);
    checkBusLine(start, 32'h24);
    checkOutput("bp_miss_count", miss_count, 32'd10);
    addr_stall = 0;
    tick();

    $display("[TB] reset in the middle of a refill");
    base_done = data_done;
    issueFetch(32'h45, 1'b0);
    for (int i = 0; i < 50 && data_done < base_done + 2; i++) tick();
    checkOutput("mid_refill_words", data_done - base_done, 32'd2);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1 checkResetOutputs("midreset");
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    start = bus_log.size();
    applyStimulus(32'h45, 0, data, lat);
    checkOutput("after_reset_data", data, 32'h6D);
    checkOutput("after_reset_latency", lat, 32'd10);
    checkBusLine(start, 32'h44);
    checkOutput("after_reset_miss_count", miss_count, 32'd1);
    checkOutput("after_reset_hit_count", hit_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mini_i_cache_lines.md
Name: mini_i_cache_lines

Overview:
Parametrised successor to the single-word instruction cache. Direct-mapped, multi-word lines, word-addressed. Sits between the instruction-fetch port (ir_*) and the memory bus (bus_ir_*). Adds line refill bursts, a flush command, and hit/miss counters.

Parameters:
DATA_WIDTH, 32, instruction word width.
ADDR_WIDTH, 32, word-address width.
LINES, 16, number of cache lines; power of 2, >=2.
WORDS_PER_LINE, 4, words per line; power of 2, >=1. A value of 1 gives the single-word-per-entry behaviour of the previous generation.
CNT_WIDTH, 32, width of the performance counters.

Ports:
clock  in  1  single clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
ir_addr_valid  in  1  fetch request valid.
ir_addr_ready  out  1  cache can accept a fetch.
ir_addr  in  ADDR_WIDTH  fetch word address.
ir_data_valid  out  1  fetch data valid.
ir_data_ready  in  1  fetcher accepts data.
ir_data  out  DATA_WIDTH  fetched word.
bus_ir_addr_valid  out  1  bus word-read request valid.
bus_ir_addr_ready  in  1  bus accepts request.
bus_ir_addr  out  ADDR_WIDTH  bus word address.
bus_ir_data_valid  in  1  bus reply valid.
bus_ir_data_ready  out  1  cache accepts reply.
bus_ir_data  in  DATA_WIDTH  bus reply word.
flush  in  1  one-cycle pulse; invalidate all lines.
hit_count  out  CNT_WIDTH  saturating count of hits.
miss_count  out  CNT_WIDTH  saturating count of misses.

Behaviour:
- Address split: OFF = log2(WORDS_PER_LINE) LSBs; IDX = next log2(LINES) bits; TAG = remaining bits.
- Reset (reset_n low, asynchronous): all valid bits 0; state IDLE; ir_addr_ready=0 while reset_n is low, then 1 in IDLE; ir_data_valid=0; bus_ir_addr_valid=0; bus_ir_data_ready=0; ir_data=0; bus_ir_addr=0; counters 0; pending flush 0. Data and tag arrays are not reset.
- State IDLE: ir_addr_ready=1. On ir_addr_valid & ir_addr_ready, register the address and go to LOOKUP.
- State LOOKUP: ir_addr_ready=0. A hit is valid[IDX] & tag[IDX]==TAG.
  - On a hit: load ir_data, increment hit_count, go to RESPOND.
  - On a miss: increment miss_count, clear valid[IDX], set word counter to 0, go to REFILL_ADDR.
- State REFILL_ADDR: bus_ir_addr_valid=1 and bus_ir_addr = {TAG,IDX,counter}. The address is held stable until bus_ir_addr_ready. Then go to REFILL_DATA.
- State REFILL_DATA: bus_ir_data_ready=1. On bus_ir_data_valid, write the word at data[IDX][counter].
  - If counter==requested OFF, also capture the word into ir_data.
  - If counter==WORDS_PER_LINE-1: write the tag, set valid[IDX]=1 (cleared instead if a flush is pending), go to RESPOND.
  - Otherwise increment counter and return to REFILL_ADDR.
  - At most one bus request is outstanding at a time. Refill always runs offset 0 to WORDS_PER_LINE-1.
- State RESPOND: ir_data_valid=1 and ir_data is held until ir_data_ready. Then clear ir_data_valid and go to IDLE.
- Hit latency: acceptance edge k gives ir_data_valid high from cycle k+2.
- Miss latency: 2 + sum of bus handshake cycles.
- flush:
  - In IDLE, LOOKUP or RESPOND it clears all valid bits on the next edge.
  - A flush in LOOKUP forces a miss.
  - A flush during REFILL_* is latched as pending. The line being refilled ends invalid and the pending flush is applied on entry to RESPOND. The CPU still receives the correct word.
  - flush coincident with ir_addr acceptance: the flush wins and the request misses.
- Counters saturate at all-ones and do not wrap.
- Indexing wraps: ir_addr values that differ only in TAG map to the same line. The new fill evicts the old line.
- ir_addr_valid while not ready is ignored. The fetcher must hold it (same rule as the bus side).
- Bus data with no outstanding request cannot occur, because bus_ir_data_ready=0 outside REFILL_DATA.

Decomposition:
- Package mini_i_cache_pkg holds: the state enum (IDLE, LOOKUP, REFILL_ADDR, REFILL_DATA, RESPOND); localparam helper functions for OFF/IDX/TAG widths; a saturating-increment function.
- One sub-module: mini_i_cache_line_store. It holds the valid/tag/data arrays and provides combinational lookup, a word write port, tag/valid set, and a clear-all port.
- The top level holds the FSM, counters and handshakes.

Test Plan:
- Reset then read 0x7B with an empty cache: bus requests 0x78, 0x79, 0x7A, 0x7B in order; reply 0xA0..0xA3; ir_data=0xA3; miss_count=1.
- After that fill, read 0x79: ir_data=0xA1 at cycle k+2; no bus_ir_addr_valid; hit_count=1.
- Conflict: fill 0x7B, then read 0xBB (0x7B+64): refill 0xB8..0xBB occurs; a re-read of 0x7B misses again.
- Flush: fill 0x00, pulse flush in IDLE, read 0x00: misses and refills 0x00..0x03. Then pulse flush during refill REFILL_DATA of 0x10: data returns, and a re-read of 0x10 misses.
- Backpressure: bus_ir_addr_ready=0 for 5 cycles, then ir_data_ready=0 for 3 cycles: bus_ir_addr and ir_data stay stable; exactly one bus_ir_addr_valid & bus_ir_addr_ready handshake occurs per word.
- Reset mid-refill (reset_n low after 2 of 4 words): all outputs return to reset values immediately; a later read of the same address misses and issues a full 4-word refill.
